// File: rtl/baccarat_ctrl.sv
// Baccarat hand sequencer: steps the card-load strobes through one hand, applies
// the third-card drawing rules and raises the win lights once the hand is settled.
module baccarat_ctrl (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       game_done,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_P1   = 4'd0,
    S_D1   = 4'd1,
    S_P2   = 4'd2,
    S_D2   = 4'd3,
    S_EVAL = 4'd4,
    S_P3   = 4'd5,
    S_BDEC = 4'd6,
    S_D3   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t     r_state;
  logic [5:0] r_load;
  logic       r_done;
  state_t     w_next;

  // Dealer third-card rule; tens and face cards count as zero.
  function automatic logic f_dealer_draw(input logic [3:0] ds, input logic [3:0] pc3);
    logic [3:0] v;
    v = (pc3 <= 4'd9) ? pc3 : 4'd0;
    return (ds <= 4'd2) ||
           ((ds == 4'd3) && (v != 4'd8)) ||
           ((ds == 4'd4) && (v >= 4'd2) && (v <= 4'd7)) ||
           ((ds == 4'd5) && (v >= 4'd4) && (v <= 4'd7)) ||
           ((ds == 4'd6) && (v >= 4'd6) && (v <= 4'd7));
  endfunction

  function automatic state_t f_next(input state_t s, input logic [3:0] ps,
                                    input logic [3:0] ds, input logic [3:0] pc3);
    state_t n;
    n = S_P1;
    case (s)
      S_P1:   n = S_D1;
      S_D1:   n = S_P2;
      S_P2:   n = S_D2;
      S_D2:   n = S_EVAL;
      S_EVAL: begin
        if ((ps >= 4'd8) || (ds >= 4'd8)) n = S_DONE;
        else if (ps <= 4'd5)              n = S_P3;
        else if (ds <= 4'd5)              n = S_D3;
        else                              n = S_DONE;
      end
      S_P3:   n = S_BDEC;
      S_BDEC: n = f_dealer_draw(ds, pc3) ? S_D3 : S_DONE;
      S_D3:   n = S_DONE;
      S_DONE: n = S_DONE;
      default: n = S_P1;
    endcase
    return n;
  endfunction

  // Strobe order: {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}.
  function automatic logic [5:0] f_loads(input state_t s);
    logic [5:0] l;
    l = 6'b000000;
    case (s)
      S_P1: l = 6'b100000;
      S_D1: l = 6'b010000;
      S_P2: l = 6'b001000;
      S_D2: l = 6'b000100;
      S_P3: l = 6'b000010;
      S_D3: l = 6'b000001;
      default: l = 6'b000000;
    endcase
    return l;
  endfunction

  assign w_next = f_next(r_state, pscore, dscore, pcard3);

  // Outputs are registered from the next state so they always match r_state.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      r_state <= S_P1;
      r_load  <= f_loads(S_P1);
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_load  <= f_loads(w_next);
      r_done  <= (w_next == S_DONE);
    end
  end

  assign load_pcard1 = r_load[5];
  assign load_dcard1 = r_load[4];
  assign load_pcard2 = r_load[3];
  assign load_dcard2 = r_load[2];
  assign load_pcard3 = r_load[1];
  assign load_dcard3 = r_load[0];
  assign game_done   = r_done;
  assign state_out   = r_state;

  // Lights track the live scores while the hand is finished; a tie lights both.
  assign player_win_light = r_done && (pscore >= dscore);
  assign dealer_win_light = r_done && (dscore >= pscore);

endmodule

// File: doc/baccarat_ctrl.md
BACCARAT_CTRL -- requirements
Module: baccarat_ctrl

Interface
REQ-001 slow_clock  input  1  sole clock; all state changes on posedge.
REQ-002 resetb  input  1  reset is synchronous and active-low.
REQ-003 pscore  input  4  player hand score from datapath, 0..9.
REQ-004 dscore  input  4  dealer hand score from datapath, 0..9.
REQ-005 pcard3  input  4  player third card rank (0 = empty, 1 = A .. 13 = K).
REQ-006 load_pcard1, load_pcard2, load_pcard3  output  1 each  player card load strobes to datapath.
REQ-007 load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card load strobes to datapath.
REQ-008 player_win_light  output  1  player wins, or tie.
REQ-009 dealer_win_light  output  1  dealer wins, or tie.
REQ-010 game_done  output  1  hand finished, lights valid.
REQ-011 state_out  output  4  current state encoding, for debug only.

Function
REQ-012 Block SHALL be a Moore FSM with states P1, D1, P2, D2, EVAL, P3, BDEC, D3, DONE; state_out = 0..8 in that order.
REQ-013 All outputs SHALL be decoded from current state only, except the win lights, which also use pscore/dscore in DONE.
REQ-014 Exactly one load strobe SHALL be high in P1, D1, P2, D2, P3, D3 (load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3 respectively); all load strobes SHALL be 0 in EVAL, BDEC, DONE.
REQ-015 Fixed transitions: P1->D1->P2->D2->EVAL, P3->BDEC, D3->DONE, one edge each.
REQ-016 DONE SHALL hold until reset.
REQ-017 EVAL, natural: if pscore>=8 or dscore>=8, next state SHALL be DONE.
REQ-018 EVAL, player draws: else if pscore<=5, next state SHALL be P3.
REQ-019 EVAL, player stands: else (pscore 6..7) next state SHALL be D3 if dscore<=5, otherwise DONE.
REQ-020 BDEC SHALL compute the third-card value v = pcard3 if pcard3<=9, otherwise 0 (10, J, Q, K).
REQ-021 BDEC, dealer draws: next state SHALL be D3 when any of the following holds, otherwise DONE.
- dscore<=2
- dscore=3 and v!=8
- dscore=4 and v in 2..7
- dscore=5 and v in 4..7
- dscore=6 and v in 6..7
REQ-022 dscore=7 in BDEC SHALL always go to DONE.
REQ-023 In DONE, game_done SHALL be 1 and the lights SHALL be:
- pscore>dscore: player_win_light=1 only
- pscore<dscore: dealer_win_light=1 only
- pscore=dscore: both lights 1
REQ-024 Outside DONE, game_done and both lights SHALL be 0.
REQ-025 Score inputs SHALL be sampled only in EVAL, BDEC and DONE; values in other states SHALL be ignored.
REQ-026 Hand length SHALL be 5 edges from P1 to EVAL exit (natural) and at most 8 edges from P1 to DONE.

Reset
REQ-027 resetb=0 at any posedge SHALL force next state P1, from any state including mid-hand (P3, BDEC, D3).
REQ-028 resetb SHALL have priority over all transitions.
REQ-029 In P1 after reset:
- load_pcard1=1, all other loads 0
- game_done=0, both lights 0, state_out=0

Verification
REQ-030 Bench SHALL cover natural: reach EVAL with pscore=8, dscore=2 -> next edge DONE; player_win_light=1, dealer_win_light=0; load_pcard3 and load_dcard3 never asserted.
REQ-031 Bench SHALL cover player draw, dealer draw: EVAL pscore=3, dscore=4 -> P3 (load_pcard3=1); BDEC pcard3=5, dscore=4 -> D3 (load_dcard3=1) -> DONE.
REQ-032 Bench SHALL cover dealer stand on an 8: EVAL pscore=4 -> P3; BDEC pcard3=8, dscore=3 -> DONE, load_dcard3 never asserted.
REQ-033 Bench SHALL cover face-card third card: BDEC pcard3=12, dscore=3 -> D3; BDEC pcard3=12, dscore=4 -> DONE.
REQ-034 Bench SHALL cover player stand and tie: EVAL pscore=6, dscore=5 -> D3 -> DONE; then with pscore=7, dscore=7 -> both lights 1, game_done=1.
REQ-035 Bench SHALL cover reset mid-hand: resetb=0 at the edge while in P3 -> state_out=0, load_pcard1=1, lights 0; resetb=1 -> P1..D2 strobes resume in order.
